// File: rtl/regbank_pkg.sv
// Shared definitions for the one-hot strobed register bank: op encodings and bank depth.
package regbank_pkg;

    localparam int NUM_REGS = 8;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

endpackage

// File: rtl/onehot_check.sv
// Classifies an 8-bit strobe as all-zero or exactly one-hot; combinational, no latency.
module onehot_check (
    input  logic [7:0] vec_i,
    output logic       is_zero_o,
    output logic       is_onehot_o
);

    logic [7:0] vec_m1;

    assign vec_m1      = vec_i - 8'd1;
    assign is_zero_o   = ~|vec_i;
    // Clearing the lowest set bit leaves zero only when a single bit was set.
    assign is_onehot_o = !is_zero_o && ((vec_i & vec_m1) == 8'd0);

endmodule

// File: rtl/onehot_regbank.sv
// Eight-entry bank written by a one-hot decoder strobe, with two registered read ports.
// Writes take effect at the edge, reads lag one cycle (no bypass); no backpressure, one write per cycle.
module onehot_regbank
    import regbank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    input  logic [NUM_REGS-1:0]  wr_onehot,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     din,
    input  logic [2:0]           rd_sel_a,
    input  logic [2:0]           rd_sel_b,
    output logic [WIDTH-1:0]     rd_a,
    output logic [WIDTH-1:0]     rd_b,
    output logic                 wr_done,
    output logic                 err_pulse,
    output logic                 err_sticky,
    input  logic                 err_clr,
    output logic [CNT_WIDTH-1:0] wr_count
);

    logic [WIDTH-1:0]     regs_q [NUM_REGS];
    logic [WIDTH-1:0]     regs_d [NUM_REGS];
    logic [WIDTH-1:0]     rd_a_q, rd_b_q;
    logic                 wr_done_q, err_pulse_q, err_sticky_q, err_sticky_d;
    logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;

    logic is_zero, is_onehot, is_multi;
    logic accept, illegal;

    onehot_check u_check (
        .vec_i       (wr_onehot),
        .is_zero_o   (is_zero),
        .is_onehot_o (is_onehot)
    );

    assign is_multi = !is_zero && !is_onehot;
    assign accept   = wr_valid && is_onehot && (op != OP_HOLD);
    assign illegal  = wr_valid && is_multi;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (accept && wr_onehot[i]) begin
                case (op)
                    OP_LOAD: regs_d[i] = din;
                    OP_INC:  regs_d[i] = regs_q[i] + WIDTH'(1);
                    OP_CLR:  regs_d[i] = '0;
                    default: regs_d[i] = regs_q[i];
                endcase
            end
        end
        wr_count_d   = accept ? wr_count_q + CNT_WIDTH'(1) : wr_count_q;
        // A new illegal strobe outranks a clear arriving on the same edge.
        err_sticky_d = illegal ? 1'b1 : (err_clr ? 1'b0 : err_sticky_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rd_a_q       <= '0;
            rd_b_q       <= '0;
            wr_done_q    <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            wr_count_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_a_q       <= regs_q[rd_sel_a];
            rd_b_q       <= regs_q[rd_sel_b];
            wr_done_q    <= accept;
            err_pulse_q  <= illegal;
            err_sticky_q <= err_sticky_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign rd_a       = rd_a_q;
    assign rd_b       = rd_b_q;
    assign wr_done    = wr_done_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_onehot_regbank.sv
// Directed table-driven bench for onehot_regbank plus async-reset and counter-wrap sequences.
module tb_onehot_regbank;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_onehot;
    logic [1:0] op;
    logic [7:0] din;
    logic [2:0] rd_sel_a, rd_sel_b;
    logic [7:0] rd_a, rd_b;
    logic       wr_done, err_pulse, err_sticky, err_clr;
    logic [7:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    onehot_regbank #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_onehot  (wr_onehot),
        .op         (op),
        .din        (din),
        .rd_sel_a   (rd_sel_a),
        .rd_sel_b   (rd_sel_b),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .wr_done    (wr_done),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_clr    (err_clr),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] oh;
        logic [1:0] op;
        logic [7:0] din;
        logic [2:0] sa;
        logic [2:0] sb;
        logic       clr;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ed;
        logic       eep;
        logic       ees;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic ed, input logic eep, input logic ees, input logic [7:0] ecnt);
        chk({tag, ".rd_a"},       32'(rd_a),       32'(ea));
        chk({tag, ".rd_b"},       32'(rd_b),       32'(eb));
        chk({tag, ".wr_done"},    32'(wr_done),    32'(ed));
        chk({tag, ".err_pulse"},  32'(err_pulse),  32'(eep));
        chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(ees));
        chk({tag, ".wr_count"},   32'(wr_count),   32'(ecnt));
    endtask

    task automatic drive(input logic v, input logic [7:0] oh, input logic [1:0] o,
                         input logic [7:0] d, input logic [2:0] sa, input logic [2:0] sb,
                         input logic clr);
        wr_valid  = v;
        wr_onehot = oh;
        op        = o;
        din       = d;
        rd_sel_a  = sa;
        rd_sel_b  = sb;
        err_clr   = clr;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Each row: inputs applied before an edge, outputs expected just after it.
        //           v     oh     op     din    sa    sb    clr   rd_a   rd_b   done  ep    es    cnt
        vecs[0]  = '{1'b1, 8'h04, 2'b01, 8'h5A, 3'd2, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[1]  = '{1'b0, 8'h00, 2'b00, 8'h00, 3'd2, 3'd0, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[2]  = '{1'b1, 8'h80, 2'b01, 8'hFF, 3'd2, 3'd7, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[3]  = '{1'b1, 8'h80, 2'b10, 8'h00, 3'd2, 3'd7, 1'b0, 8'h5A, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd3};
        vecs[4]  = '{1'b0, 8'h00, 2'b00, 8'h00, 3'd2, 3'd7, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 8'd3};
        vecs[5]  = '{1'b1, 8'h01, 2'b01, 8'h33, 3'd0, 3'd1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'd4};
        vecs[6]  = '{1'b1, 8'h02, 2'b01, 8'h44, 3'd0, 3'd1, 1'b0, 8'h33, 8'h00, 1'b1, 1'b0, 1'b0, 8'd5};
        vecs[7]  = '{1'b1, 8'h03, 2'b01, 8'hAA, 3'd0, 3'd1, 1'b0, 8'h33, 8'h44, 1'b0, 1'b1, 1'b1, 8'd5};
        vecs[8]  = '{1'b0, 8'h00, 2'b00, 8'h00, 3'd0, 3'd1, 1'b0, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1, 8'd5};
        vecs[9]  = '{1'b1, 8'hFF, 2'b11, 8'h00, 3'd0, 3'd1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 1'b1, 8'd5};
        vecs[10] = '{1'b0, 8'h00, 2'b00, 8'h00, 3'd0, 3'd1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 8'd5};
        vecs[11] = '{1'b1, 8'h08, 2'b01, 8'h11, 3'd3, 3'd3, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'd6};
        vecs[12] = '{1'b0, 8'h00, 2'b00, 8'h00, 3'd3, 3'd3, 1'b0, 8'h11, 8'h11, 1'b0, 1'b0, 1'b0, 8'd6};
        vecs[13] = '{1'b1, 8'h00, 2'b01, 8'h77, 3'd3, 3'd2, 1'b0, 8'h11, 8'h5A, 1'b0, 1'b0, 1'b0, 8'd6};
        vecs[14] = '{1'b1, 8'h08, 2'b00, 8'h99, 3'd3, 3'd2, 1'b0, 8'h11, 8'h5A, 1'b0, 1'b0, 1'b0, 8'd6};
        vecs[15] = '{1'b0, 8'hFF, 2'b01, 8'hEE, 3'd3, 3'd2, 1'b0, 8'h11, 8'h5A, 1'b0, 1'b0, 1'b0, 8'd6};
        vecs[16] = '{1'b0, 8'h00, 2'b00, 8'h00, 3'd3, 3'd0, 1'b0, 8'h11, 8'h33, 1'b0, 1'b0, 1'b0, 8'd6};
        vecs[17] = '{1'b0, 8'h00, 2'b00, 8'h00, 3'd1, 3'd7, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0, 1'b0, 8'd6};
        vecs[18] = '{1'b1, 8'h04, 2'b11, 8'h00, 3'd2, 3'd0, 1'b0, 8'h5A, 8'h33, 1'b1, 1'b0, 1'b0, 8'd7};
        vecs[19] = '{1'b0, 8'h00, 2'b00, 8'h00, 3'd2, 3'd0, 1'b0, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0, 8'd7};

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 2'b00, 8'h00, 3'd0, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk_all("reset_held", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        step();
        chk_all("reset_release", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].v, vecs[i].oh, vecs[i].op, vecs[i].din, vecs[i].sa, vecs[i].sb, vecs[i].clr);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ed,
                    vecs[i].eep, vecs[i].ees, vecs[i].ecnt);
        end

        // Async reset mid-burst, asserted between edges.
        drive(1'b1, 8'h20, 2'b01, 8'hC3, 3'd5, 3'd3, 1'b0);
        step();
        drive(1'b1, 8'h20, 2'b10, 8'h00, 3'd5, 3'd3, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        drive(1'b0, 8'h00, 2'b00, 8'h00, 3'd5, 3'd3, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("post_rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(1'b0, 8'h00, 2'b00, 8'h00, 3'd2, 3'd0, 1'b0);
        step();
        chk_all("post_rst_read", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);

        // 256 increments of reg5: register and counter both wrap back to 0.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 8'h20, 2'b10, 8'h00, 3'd5, 3'd5, 1'b0);
            step();
        end
        chk("wrap.wr_count", 32'(wr_count), 32'd0);
        chk("wrap.wr_done", 32'(wr_done), 32'd1);
        drive(1'b1, 8'h20, 2'b10, 8'h00, 3'd5, 3'd5, 1'b0);
        step();
        chk_all("wrap_plus1", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1);
        drive(1'b0, 8'h00, 2'b00, 8'h00, 3'd5, 3'd0, 1'b0);
        step();
        chk_all("wrap_read", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
